// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//
// Fills the pipelined core's instruction memory from a UART byte stream and
// then releases the core from reset.
//
// Frame: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data
// bytes (each word LSB first), then CHK. CHK is the XOR of every byte from
// LEN_LO through the last data byte. Words go to consecutive addresses from 0.
// A length above 2^ADDR_W, a bad checksum or (optionally) an inter-byte
// timeout holds the core in reset and raises boot_error.
//
// Optional feature macro: BOOT_TIMEOUT_EN
//   When defined, a counter watches for an idle receive stream in LEN_HI,
//   DATA and CHECK. After TIMEOUT_CYCLES cycles with no accepted byte the
//   loader goes to ERROR. When undefined, no counter exists and the loader
//   waits indefinitely.
//
// Ports:
//   CLK_50        in   system clock
//   reset         in   asynchronous active-high reset
//   rx_valid      in   byte available from the UART receiver
//   rx_data       in   received byte
//   rx_ready      out  loader accepts a byte (transfer = rx_valid && rx_ready)
//   reload        in   single-cycle pulse, re-arms from DONE or ERROR
//   imem_we       out  instruction-memory write strobe (one cycle per word)
//   imem_addr     out  instruction-memory word address
//   imem_wdata    out  instruction-memory write data
//   cpu_reset     out  active-high reset to the core
//   boot_done     out  image loaded and verified
//   boot_error    out  length, checksum or timeout fault
//   words_loaded  out  number of words written in the current load
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              CLK_50,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              boot_done,
  output logic              boot_error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_LEN_LO = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERROR  = 3'd5;

  // Largest legal word count, held in 17 bits so 2^16 is representable.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_reset_q, cpu_reset_d;

  logic              accept;
  logic [15:0]       len_full;
  logic [16:0]       words_next;

`ifdef BOOT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              timed;
`endif

  assign rx_ready     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
  assign accept       = rx_valid && rx_ready;
  assign boot_done    = (state_q == S_DONE);
  assign boot_error   = (state_q == S_ERROR);
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_reset    = cpu_reset_q;
  assign words_loaded = words_q;

  // Word count as it would be with the LEN_HI byte currently on rx_data.
  assign len_full   = {rx_data, len_q[7:0]};
  // Count including the word whose last byte is being accepted now.
  assign words_next = 17'(words_q) + 17'd1;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    chk_d       = chk_q;
    words_d     = words_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;

    // words_loaded advances the cycle after the write strobe. Bytes arrive
    // at most one per cycle, so the count is current before the next word's
    // last byte can be compared against the length.
    if (we_q) begin
      words_d = words_q + 1'b1;
    end

    // Every byte before CHK feeds the running XOR.
    if (accept && (state_q != S_CHECK)) begin
      chk_d = chk_q ^ rx_data;
    end

    case (state_q)
      S_LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          byte_cnt_d  = 2'd0;
          if ({1'b0, len_full} > MAX_WORDS) begin
            state_d = S_ERROR;
          end else if (len_full == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: shift_d[7:0]   = rx_data;
            2'd1: shift_d[15:8]  = rx_data;
            2'd2: shift_d[23:16] = rx_data;
            default: begin
              we_d    = 1'b1;
              wdata_d = {rx_data, shift_q};
              addr_d  = words_q[ADDR_W-1:0];
              if (words_next == {1'b0, len_q}) begin
                state_d = S_CHECK;
              end
            end
          endcase
        end
      end
      S_CHECK: begin
        if (accept) begin
          state_d = (rx_data == chk_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (reload) begin
          state_d    = S_LEN_LO;
          len_d      = '0;
          byte_cnt_d = '0;
          shift_d    = '0;
          chk_d      = '0;
          words_d    = '0;
          addr_d     = '0;
          wdata_d    = '0;
        end
      end
      default: state_d = S_ERROR;
    endcase

    // The core leaves reset one cycle after DONE is entered; a reload pulse
    // puts it back into reset on the following cycle.
    cpu_reset_d = !((state_q == S_DONE) && !reload);

`ifdef BOOT_TIMEOUT_EN
    // Idle counter restarts on every accepted byte and on any state change.
    timed = (state_q == S_LEN_HI) || (state_q == S_DATA) || (state_q == S_CHECK);
    tmo_d = tmo_q + 1'b1;
    if (timed && !accept && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_ERROR;
    end
    if (!timed || accept || (state_d != state_q)) begin
      tmo_d = '0;
    end
`endif
  end

  // All loader state, with the core held in reset while reset is asserted.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= S_LEN_LO;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      chk_q       <= '0;
      words_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_reset_q <= 1'b1;
`ifdef BOOT_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      chk_q       <= chk_d;
      words_q     <= words_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef BOOT_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//
// Directed frames are built into a byte queue; every word that should reach
// instruction memory is pushed into an expectation queue as the frame is
// built. A separate monitor pops an expectation on every write strobe.
// Status outputs are compared directly after each frame.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK_50;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        boot_done;
  logic        boot_error;
  logic [8:0]  words_loaded;

  int          compared;
  int          mismatched;
  logic [7:0]  frameQ[$];
  wr_t         expQ[$];
  int          nextAddr;
  logic [7:0]  runChk;

  imem_boot_loader #(
    .ADDR_W(8)
`ifdef BOOT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .CLK_50      (CLK_50),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .reload      (reload),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset   (cpu_reset),
    .boot_done   (boot_done),
    .boot_error  (boot_error),
    .words_loaded(words_loaded)
  );

  // 50 MHz clock.
  initial CLK_50 = 1'b0;
  always #10 CLK_50 = ~CLK_50;

  // Hard stop in case a frame never completes.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Write monitor: each strobe must match the oldest outstanding expectation.
  always @(negedge CLK_50) begin
    if (imem_we) begin
      compared++;
      if (expQ.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL unexpected_write: got addr=%0h data=%08h, required no write", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        if (imem_addr !== e.addr || imem_wdata !== e.data) begin
          mismatched++;
          $display("[TB] FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   imem_addr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic checkStatus(input string tag, input logic done, input logic err,
                             input logic cpuRst, input logic [8:0] words);
    checkOutput({tag, "_boot_done"}, 32'(boot_done), 32'(done));
    checkOutput({tag, "_boot_error"}, 32'(boot_error), 32'(err));
    checkOutput({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cpuRst));
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'(words));
  endtask

  task automatic pushByte(input logic [7:0] b);
    frameQ.push_back(b);
    runChk = runChk ^ b;
  endtask

  task automatic startFrame(input int n);
    frameQ.delete();
    nextAddr = 0;
    runChk   = 8'h00;
    pushByte(n[7:0]);
    pushByte(n[15:8]);
  endtask

  task automatic addWord(input logic [31:0] w, input bit expectWrite);
    pushByte(w[7:0]);
    pushByte(w[15:8]);
    pushByte(w[23:16]);
    pushByte(w[31:24]);
    if (expectWrite) begin
      expQ.push_back('{addr: nextAddr[7:0], data: w});
    end
    nextAddr++;
  endtask

  task automatic endFrame(input logic [7:0] corrupt);
    frameQ.push_back(runChk ^ corrupt);
  endtask

  // One byte handshake; inputs change 1 ns after the rising edge.
  task automatic sendByte(input logic [7:0] b);
    bit done;
    done     = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 20 && !done; t++) begin
      done = rx_ready;
      @(posedge CLK_50);
      #1;
    end
    rx_valid = 1'b0;
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL rx_handshake: byte %02h not accepted, required accept within 20 cycles", b);
    end
  endtask

  // Sends the first count bytes of the frame (all if count < 0) with
  // 0..maxGap idle cycles between bytes.
  task automatic applyStimulus(input int maxGap, input int count);
    int n;
    n = (count < 0) ? frameQ.size() : count;
    for (int i = 0; i < n; i++) begin
      sendByte(frameQ[i]);
      if (maxGap > 0) begin
        repeat ($urandom_range(maxGap, 0)) begin
          @(posedge CLK_50);
          #1;
        end
      end
    end
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(posedge CLK_50);
    #1;
    reload = 1'b0;
    checkStatus("after_reload", 1'b0, 1'b0, 1'b1, 9'd0);
    checkOutput("after_reload_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    reload     = 1'b0;

    // Reset values.
    #5;
    checkStatus("reset", 1'b0, 1'b0, 1'b1, 9'd0);
    checkOutput("reset_imem_we", 32'(imem_we), 32'd0);
    checkOutput("reset_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("reset_imem_wdata", imem_wdata, 32'd0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge CLK_50);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge CLK_50);
    #1;

    // Single word, hand-built frame, back-to-back bytes.
    frameQ = '{8'h01, 8'h00, 8'h04, 8'h00, 8'hA0, 8'hE3, 8'h46};
    expQ.push_back('{addr: 8'h00, data: 32'hE3A00004});
    applyStimulus(0, -1);
    checkStatus("one_word_entry", 1'b1, 1'b0, 1'b1, 9'd1);
    checkOutput("one_word_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge CLK_50);
    #1;
    checkOutput("one_word_cpu_reset_fall", 32'(cpu_reset), 32'd0);

    // Bytes offered in DONE must not be consumed.
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) @(posedge CLK_50);
    #1;
    rx_valid = 1'b0;
    checkStatus("done_ignores_rx", 1'b1, 1'b0, 1'b0, 9'd1);
    pulseReload();

    // Three words with random inter-byte gaps.
    startFrame(3);
    addWord(32'hE3A00001, 1'b1);
    addWord(32'hE3A01002, 1'b1);
    addWord(32'hE0812000, 1'b1);
    endFrame(8'h00);
    applyStimulus(5, -1);
    @(posedge CLK_50);
    #1;
    checkStatus("three_words", 1'b1, 1'b0, 1'b0, 9'd3);
    pulseReload();

    // Empty image.
    frameQ = '{8'h00, 8'h00, 8'h00};
    applyStimulus(0, -1);
    @(posedge CLK_50);
    #1;
    checkStatus("empty_image", 1'b1, 1'b0, 1'b0, 9'd0);
    pulseReload();

    // Wrong checksum, then a reload and a good frame.
    startFrame(1);
    addWord(32'hE3A0000A, 1'b1);
    endFrame(8'h01);
    applyStimulus(0, -1);
    @(posedge CLK_50);
    #1;
    checkStatus("bad_chk", 1'b0, 1'b1, 1'b1, 9'd1);
    checkOutput("bad_chk_rx_ready", 32'(rx_ready), 32'd0);
    pulseReload();
    startFrame(1);
    addWord(32'hE1A0F00E, 1'b1);
    endFrame(8'h00);
    applyStimulus(0, -1);
    @(posedge CLK_50);
    #1;
    checkStatus("after_error_boot", 1'b1, 1'b0, 1'b0, 9'd1);
    pulseReload();

    // N = 257 is too long: error right after LEN_HI, no writes.
    frameQ = '{8'h01, 8'h01};
    applyStimulus(0, -1);
    checkStatus("len_257", 1'b0, 1'b1, 1'b1, 9'd0);
    checkOutput("len_257_rx_ready", 32'(rx_ready), 32'd0);
    pulseReload();

    // N = 256 fills the whole memory; last address 0xFF.
    startFrame(256);
    for (int i = 0; i < 256; i++) begin
      addWord({8'hE1, i[7:0], 8'hA5, ~i[7:0]}, 1'b1);
    end
    endFrame(8'h00);
    applyStimulus(0, -1);
    @(posedge CLK_50);
    #1;
    checkStatus("len_256", 1'b1, 1'b0, 1'b0, 9'd256);
    checkOutput("len_256_last_addr", 32'(imem_addr), 32'h0000_00FF);
    pulseReload();

    // Reset during the second data word.
    startFrame(2);
    addWord(32'h11223344, 1'b1);
    addWord(32'h55667788, 1'b0);
    endFrame(8'h00);
    applyStimulus(0, 8);
    repeat (2) @(posedge CLK_50);
    #1;
    reset = 1'b1;
    #2;
    checkStatus("mid_reset", 1'b0, 1'b0, 1'b1, 9'd0);
    checkOutput("mid_reset_rx_ready", 32'(rx_ready), 32'd1);
    @(posedge CLK_50);
    #1;
    reset = 1'b0;
    frameQ = '{8'h00, 8'h00, 8'h00};
    applyStimulus(0, -1);
    @(posedge CLK_50);
    #1;
    checkStatus("after_mid_reset", 1'b1, 1'b0, 1'b0, 9'd0);
    pulseReload();

`ifdef BOOT_TIMEOUT_EN
    // Stall inside DATA until the inter-byte timeout fires.
    startFrame(1);
    addWord(32'hCAFEF00D, 1'b0);
    endFrame(8'h00);
    applyStimulus(0, 4);
    repeat (90) @(posedge CLK_50);
    #1;
    checkOutput("timeout_not_yet", 32'(boot_error), 32'd0);
    repeat (20) @(posedge CLK_50);
    #1;
    checkStatus("timeout", 1'b0, 1'b1, 1'b1, 9'd0);
    pulseReload();
`endif

    repeat (3) @(posedge CLK_50);
    #1;
    checkOutput("writes_outstanding", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Sits directly upstream of the pipelined ARM core's instruction memory and drives the core's reset. It fills the memory and then releases the core.
- Consumes a byte stream from the board UART receiver and assembles little-endian 32-bit words. Each word is written to consecutive instruction-memory addresses.
- After the image's checksum verifies, the loader deasserts cpu_reset and the core fetches from address 0.
- On any protocol fault, the core stays in reset and an error flag is raised.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words.
- TIMEOUT_CYCLES, 5000000, inter-byte timeout in CLK_50 cycles (100 ms). Used only with BOOT_TIMEOUT_EN.

Ports:
- CLK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_valid  in  1  byte available from the UART receiver.
- rx_data  in  8  received byte.
- rx_ready  out  1  loader accepts a byte; a transfer happens when rx_valid && rx_ready on a rising edge.
- reload  in  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  instruction-memory word address.
- imem_wdata  out  32  instruction-memory write data.
- cpu_reset  out  1  reset to the pipelined core, active-high.
- boot_done  out  1  image loaded and verified.
- boot_error  out  1  length, checksum or timeout fault.
- words_loaded  out  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (asynchronous, active-high): state=LEN_LO. All counters, the checksum and the word shift register clear.
  - Output reset values: cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0, boot_done=0, boot_error=0, words_loaded=0, rx_ready=1.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word LSB first), then CHK.
  - CHK is the XOR of every byte from LEN_LO through the last data byte.
- States:
  - LEN_LO: on accept, latch N[7:0] -> LEN_HI.
  - LEN_HI: on accept, latch N[15:8].
    - N > 2^ADDR_W -> ERROR.
    - N == 0 -> CHECK.
    - Otherwise -> DATA.
  - DATA: byte counter b (0..3) places the byte at bits [8b+7:8b] of the shift register.
    - On the 4th byte: next cycle imem_we=1 for exactly one cycle, with imem_wdata=assembled word and imem_addr=word index. The index then increments and words_loaded increments.
    - After word N is accepted -> CHECK.
  - CHECK: on accept, compare the byte with the running XOR.
    - Equal -> DONE.
    - Not equal -> ERROR.
  - DONE: rx_ready=0, boot_done=1; cpu_reset falls on the cycle after entry (registered) and stays 0.
  - ERROR: rx_ready=0, boot_error=1, cpu_reset stays 1.
- rx_ready=1 in LEN_LO, LEN_HI, DATA and CHECK, and 0 in DONE and ERROR.
  - Bytes presented in DONE or ERROR are not consumed.
- reload in DONE or ERROR: next state LEN_LO, cpu_reset=1 the following cycle, and boot_done, boot_error, words_loaded, address and checksum clear.
  - reload in any other state is ignored.
- The last write strobe and the DONE entry never overlap. The CHK byte arrives at least one cycle after the final imem_we.
- reset mid-load: returns to LEN_LO immediately. Partially written memory is left as is; cpu_reset=1.
- N == 2^ADDR_W is legal; the final imem_addr is 2^ADDR_W-1, and the address does not wrap before CHECK.
- The checksum is 8-bit XOR. The address and counters are unsigned and never wrap within a legal frame.

Optional Feature:
- BOOT_TIMEOUT_EN defined:
  - A counter resets on every accepted byte and on state entry.
  - In LEN_HI, DATA or CHECK, once TIMEOUT_CYCLES cycles pass with no accepted byte, go to ERROR.
  - LEN_LO never times out.
- BOOT_TIMEOUT_EN undefined: no counter is instantiated, and the loader waits indefinitely.

Test Plan:
- Frame 01 00 | 04 00 A0 E3 | CHK=0x46, bytes back-to-back -> one imem_we with addr 0 and wdata 0xE3A00004; then words_loaded=1, boot_done=1, and cpu_reset falls one cycle after DONE entry.
- Frame N=3 with rx_valid gaps of 0-5 random cycles -> three writes at addrs 0,1,2 with the correct words; final state DONE.
- Frame 00 00, CHK=0x00 -> no imem_we, DONE, cpu_reset=0.
- Frame N=1 with wrong CHK (correct value XOR 0x01) -> ERROR, boot_error=1, cpu_reset=1. Then a reload pulse -> LEN_LO, errors cleared, and a correct frame boots.
- ADDR_W=8, LEN=01 01 (N=257) -> ERROR right after LEN_HI with no writes. With N=256, the last write has addr 0xFF and the result is DONE.
- Assert reset during the 2nd data word -> cpu_reset=1 and state LEN_LO. With BOOT_TIMEOUT_EN and TIMEOUT_CYCLES=100, stalling 100 cycles in DATA -> ERROR.
